// File: rtl/axis_ask_uart_rx_wrapper.sv
// axis_ask_uart_rx_wrapper: decodes a 2-bit ASK symbol stream (11 mark, 01 space,
// 00 no carrier, 10 invalid) into 8N1 bytes and queues them in a first-word-fall-through
// FIFO behind an AXI-Stream master port.
// Build option: define ASK_RX_MAJORITY_EN to replace each single sample with a 2-of-3
// vote over the cycles around the nominal sample point (one extra clock of latency).
module axis_ask_uart_rx_wrapper #(
  parameter int unsigned clkdiv_rx = 100,
  parameter int unsigned RX_SIZE   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] ask_rx,
  output logic [7:0] o_tdata,
  output logic       o_tvalid,
  input  logic       o_tready,
  output logic       o_frame_err,
  output logic       o_overflow
);

  localparam int unsigned   DEPTH   = 1 << RX_SIZE;
  localparam logic [16:0]   MID_C   = 17'(clkdiv_rx / 2);
  localparam logic [16:0]   LAST_C  = 17'(clkdiv_rx - 1);
  localparam logic [RX_SIZE:0] DEPTH_C = (RX_SIZE + 1)'(DEPTH);
`ifdef ASK_RX_MAJORITY_EN
  // The vote resolves one cycle after the nominal point, so the next bit starts at 1
  // to keep the bit period at clkdiv_rx.
  localparam logic [16:0]   RESTART_C = 17'd1;
`else
  localparam logic [16:0]   RESTART_C = 17'd0;
`endif

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e        state_q, state_d;
  logic [1:0]    sync1_q, sync2_q, sym;
  logic [1:0]    vld_q;
  logic          armed_q;
  logic [16:0]   cnt_q, cnt_d, samp_pt;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          err_q, err_d;
  logic          eval;
  logic [1:0]    samp;
  logic          push, bad;
  logic [7:0]    mem_q [DEPTH];
  logic [RX_SIZE:0] wr_q, rd_q, count;
  logic          full, pop;
  logic          ferr_q, ovf_q;

  assign sym     = sync2_q;
  assign samp_pt = (state_q == START) ? MID_C : LAST_C;

  // Two-flop synchroniser; a start is only accepted once the real line has been seen away from 01
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
      vld_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      sync1_q <= ask_rx;
      sync2_q <= sync1_q;
      vld_q   <= {vld_q[0], 1'b1};
      if (vld_q[1] && (sync2_q != 2'b01)) armed_q <= 1'b1;
    end
  end

`ifdef ASK_RX_MAJORITY_EN
  logic [1:0] v0_q, v1_q;

  // Capture the two symbols preceding the vote cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_q <= 2'b11;
      v1_q <= 2'b11;
    end else begin
      if (cnt_q == samp_pt - 17'd1) v0_q <= sym;
      if (cnt_q == samp_pt)         v1_q <= sym;
    end
  end

  assign eval = (cnt_q == samp_pt + 17'd1);
  assign samp = (v0_q & v1_q) | (v0_q & sym) | (v1_q & sym);
`else
  assign eval = (cnt_q == samp_pt);
  assign samp = sym;
`endif

  // Receiver state, bit timing and shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      err_q   <= err_d;
    end
  end

  // Frame decoding: start validation, LSB-first data, stop check
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 17'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
    err_d   = err_q;
    push    = 1'b0;
    bad     = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (armed_q && (sym == 2'b01)) begin
          state_d = START;
          err_d   = 1'b0;
        end
      end
      START: begin
        if (eval) begin
          if (samp != 2'b01) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            cnt_d   = RESTART_C;
            bit_d   = '0;
          end
        end
      end
      DATA: begin
        if (eval) begin
          shift_d = {samp[1], shift_q[7:1]};
          if (!samp[0]) err_d = 1'b1;
          cnt_d = RESTART_C;
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      STOP: begin
        if (eval) begin
          state_d = IDLE;
          if ((samp == 2'b11) && !err_q) push = 1'b1;
          else                           bad  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign count    = wr_q - rd_q;
  assign full     = (count == DEPTH_C);
  assign o_tvalid = (wr_q != rd_q);
  assign pop      = o_tvalid & o_tready;
  assign o_tdata  = mem_q[rd_q[RX_SIZE-1:0]];

  // FIFO storage and pointers; a push into a full FIFO is dropped even if a pop coincides
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      ferr_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (push && !full) begin
        mem_q[wr_q[RX_SIZE-1:0]] <= shift_q;
        wr_q <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      ferr_q <= bad;
      ovf_q  <= push & full;
    end
  end

  assign o_frame_err = ferr_q;
  assign o_overflow  = ovf_q;

endmodule

// File: tb/tb_axis_ask_uart_rx_wrapper.sv
// Bench for axis_ask_uart_rx_wrapper: directed frames plus randomized traffic, checked
// every cycle against a frame-level model (expected outcome per frame + FIFO queue).
module tb_axis_ask_uart_rx_wrapper;

  localparam int CLKDIV = 100;
  localparam int MID    = CLKDIV / 2;
`ifdef ASK_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif
  // Edges from the first start-symbol drive to the cycle the result is visible.
  localparam int LAT = 4 + MID + 9 * CLKDIV + MAJ;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] ask_rx = 2'b11;
  logic       o_tready = 1'b0;
  logic [7:0] o_tdata;
  logic       o_tvalid, o_frame_err, o_overflow;

  axis_ask_uart_rx_wrapper #(.clkdiv_rx(CLKDIV), .RX_SIZE(4)) dut (
    .clk(clk), .rst_n(rst_n), .ask_rx(ask_rx),
    .o_tdata(o_tdata), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .o_frame_err(o_frame_err), .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {int at; bit good; logic [7:0] data;} ev_t;
  ev_t        evq[$];
  logic [7:0] mq[$];
  logic [7:0] seen[$];
  bit         exp_ferr, exp_ovf;
  int         checks = 0, errors = 0;
  int         n_ferr = 0, n_ovf = 0;
  bit         chk_en = 1'b0;
  bit         rnd_tready = 1'b0;
  int         m_now, m_sz;
  bit         m_pop;
  ev_t        m_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  // Model: frame outcomes land LAT edges after the frame began; FIFO as a queue.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      evq.delete();
      exp_ferr = 1'b0;
      exp_ovf  = 1'b0;
    end else begin
      m_now = int'($time / 10);
      m_sz  = mq.size();
      m_pop = (m_sz != 0) && o_tready;
      exp_ferr = 1'b0;
      exp_ovf  = 1'b0;
      while (evq.size() != 0 && evq[0].at <= m_now) begin
        m_e = evq.pop_front();
        if (!m_e.good)     exp_ferr = 1'b1;
        else if (m_sz == 16) exp_ovf = 1'b1;
        else               mq.push_back(m_e.data);
      end
      if (m_pop) void'(mq.pop_front());
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("tvalid", o_tvalid, mq.size() != 0);
      if (mq.size() != 0) chk("tdata", o_tdata, mq[0]);
      chk("frame_err", o_frame_err, exp_ferr);
      chk("overflow", o_overflow, exp_ovf);
      if (o_frame_err) n_ferr++;
      if (o_overflow)  n_ovf++;
      if (o_tvalid && o_tready) seen.push_back(o_tdata);
    end
  end

  task automatic step();
    if (rnd_tready) o_tready = ($urandom_range(0, 3) != 0);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    ask_rx = 2'b11;
    repeat (n) step();
  endtask

  // Plays one frame (or its first ncyc cycles) and registers its expected outcome.
  task automatic send(input logic [7:0] b, input logic [1:0] stop_s, input int bad_bit,
                      input logic [1:0] bad_s, input logic [3:0] spike,
                      input logic [7:0] exp_b, input int ncyc);
    ev_t e;
    e.at   = int'($time / 10) + LAT;
    e.good = (stop_s == 2'b11) && (bad_bit < 0);
    e.data = exp_b;
    evq.push_back(e);
    for (int i = 0; i < ncyc; i++) begin
      logic [1:0] s;
      int bitn;
      bitn = i / CLKDIV;
      if (bitn == 0)      s = 2'b01;
      else if (bitn == 9) s = stop_s;
      else                s = b[bitn-1] ? 2'b11 : 2'b01;
      if (bitn >= 1 && bitn <= 8 && (bitn - 1) == bad_bit) s = bad_s;
      if (bitn >= 5 && bitn <= 8 && spike[bitn-5] && i == 1 + MID + bitn * CLKDIV) s = 2'b01;
      ask_rx = s;
      step();
    end
  endtask

  task automatic good(input logic [7:0] b);
    send(b, 2'b11, -1, 2'b11, 4'h0, b, 10 * CLKDIV);
  endtask

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tdata", o_tdata, 8'h00);
    chk("rst_tvalid", o_tvalid, 1'b0);
    chk("rst_frame_err", o_frame_err, 1'b0);
    chk("rst_overflow", o_overflow, 1'b0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    idle(20);

    // Single frame
    o_tready = 1'b1;
    good(8'hA5);
    idle(50);
    chk("t1_count", seen.size(), 1);
    chk("t1_byte", seen[0], 8'hA5);
    chk("t1_ferr", n_ferr, 0);

    // Short 01 glitch is rejected, following frame is clean
    ask_rx = 2'b01;
    repeat (30) step();
    idle(150);
    good(8'h3C);
    idle(50);
    chk("t2_count", seen.size(), 2);
    chk("t2_byte", seen[1], 8'h3C);
    chk("t2_ferr", n_ferr, 0);

    // Bad stop symbol, then a no-carrier data bit
    send(8'h55, 2'b01, -1, 2'b11, 4'h0, 8'h55, 10 * CLKDIV);
    idle(200);
    send(8'hFF, 2'b11, 3, 2'b00, 4'h0, 8'hFF, 10 * CLKDIV);
    idle(50);
    chk("t3_ferr", n_ferr, 2);
    chk("t3_count", seen.size(), 2);

    // Overflow with consumer stalled, back-to-back frames
    o_tready = 1'b0;
    for (int i = 0; i <= 16; i++) good(8'(i));
    idle(50);
    chk("t4_ovf", n_ovf, 1);
    o_tready = 1'b1;
    idle(40);
    chk("t4_count", seen.size(), 18);
    for (int i = 0; i < 16; i++) chk("t4_order", seen[2+i], 32'(i));

    // Reset mid-frame flushes the FIFO; a line at 01 on release is not a start
    o_tready = 1'b0;
    good(8'h11);
    idle(20);
    send(8'h00, 2'b11, -1, 2'b11, 4'h0, 8'h00, 5 * CLKDIV + MID);
    rst_n = 1'b0;
    ask_rx = 2'b01;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (20) step();
    o_tready = 1'b1;
    idle(150);
    good(8'h81);
    idle(50);
    chk("t5_count", seen.size(), 19);
    chk("t5_byte", seen[18], 8'h81);

    // One-clock 01 spikes on the sample points of data bits 4..7
    send(8'hF0, 2'b11, -1, 2'b11, 4'hF, (MAJ != 0) ? 8'hF0 : 8'h00, 10 * CLKDIV);
    idle(50);
    chk("t6_count", seen.size(), 20);
    chk("t6_byte", seen[19], (MAJ != 0) ? 8'hF0 : 8'h00);

    // Randomized traffic with random back-pressure
    rnd_tready = 1'b1;
    for (int f = 0; f < 25; f++) begin
      logic [7:0] b;
      int kind, gap;
      b    = 8'($urandom);
      kind = $urandom_range(0, 9);
      gap  = $urandom_range(0, 60);
      if (kind == 0) begin
        send(b, 2'b01, -1, 2'b11, 4'h0, b, 10 * CLKDIV);
        gap += 150;
      end else if (kind == 1) begin
        send(b, 2'b11, $urandom_range(0, 7), ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b00,
             4'h0, b, 10 * CLKDIV);
      end else begin
        good(b);
      end
      idle(gap);
    end
    rnd_tready = 1'b0;
    o_tready = 1'b1;
    idle(200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
